// File: rtl/mips_wb_pkg.sv
// Shared writeback types: register file geometry,
// result-source select encoding and the result bundle.
package mips_wb_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  localparam logic [RF_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LD   = 2'd2,
    SRC_MDU  = 2'd3
  } src_e;

  typedef struct packed {
    logic [RF_AW-1:0] wa;
    logic [RF_DW-1:0] wd;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register outstanding-write counters for RAW hazard checks.
// Saturating up on issue, floored down on retire.
module wb_scoreboard
  import mips_wb_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [RF_AW-1:0] inc_wa,
  input  logic             dec,
  input  logic [RF_AW-1:0] dec_wa,
  input  logic [RF_AW-1:0] q_a1,
  input  logic [RF_AW-1:0] q_a2,
  output logic             busy1,
  output logic             busy2,
  input  logic [RF_AW-1:0] sat_wa,
  output logic             sat
);

  localparam int NREG = 1 << RF_AW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic             up [NREG];
  logic             dn [NREG];

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      up[i] = 1'b0;
      dn[i] = 1'b0;
      if (i != 0) begin
        up[i] = inc && (inc_wa == RF_AW'(i))
                && (cnt_q[i] != CNT_MAX);
        dn[i] = dec && (dec_wa == RF_AW'(i));
      end
    end
  end

  // Issue and retire on the same edge cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i == 0) begin
          cnt_q[i] <= '0;
        end else if (up[i] && !dn[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end else if (dn[i] && !up[i]
                     && cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - CNT_ONE;
        end
      end
    end
  end

  assign busy1 = (q_a1 != REG_ZERO)
                 && (cnt_q[q_a1] != '0);
  assign busy2 = (q_a2 != REG_ZERO)
                 && (cnt_q[q_a2] != '0);
  assign sat   = (cnt_q[sat_wa] == CNT_MAX);

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Arbitrates ALU / load / MDU results onto the RF write port
// and tracks pending destination writes for issue stalls.
module rf_writeback_arbiter
  import mips_wb_pkg::*;
#(
  parameter int SB_CNT_W   = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [RF_AW-1:0] alu_wa,
  input  logic [RF_DW-1:0] alu_wd,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [RF_AW-1:0] ld_wa,
  input  logic [RF_DW-1:0] ld_wd,
  input  logic             mdu_valid,
  output logic             mdu_ready,
  input  logic [RF_AW-1:0] mdu_wa,
  input  logic [RF_DW-1:0] mdu_wd,
  input  logic             iss_en,
  input  logic [RF_AW-1:0] iss_wa,
  output logic             iss_ready,
  input  logic [RF_AW-1:0] chk_a1,
  input  logic [RF_AW-1:0] chk_a2,
  output logic             busy1,
  output logic             busy2,
  output logic             Wen,
  output logic [RF_AW-1:0] Wa,
  output logic [RF_DW-1:0] Wd
);

  localparam int ST_W = $clog2(STARVE_MAX + 1);
  localparam logic [ST_W-1:0] ST_MAX =
    ST_W'(STARVE_MAX);
  localparam logic [ST_W-1:0] ST_LAST =
    ST_W'(STARVE_MAX - 1);

  logic [ST_W-1:0] st_cnt_q;
  logic            starve_q;
  src_e            sel;
  wb_req_t         req;
  logic            grant;
  logic            wr;
  logic            mdu_go;
  logic            mdu_stall;
  logic            sat;
  logic            inc;

  assign ld_ready  = !alu_valid
                     && !(starve_q && mdu_valid);
  assign mdu_ready = !alu_valid
                     && (starve_q || !ld_valid);

  always_comb begin
    sel = SRC_NONE;
    req = '0;
    unique case (1'b1)
      alu_valid: begin
        sel = SRC_ALU;
        req = '{wa: alu_wa, wd: alu_wd};
      end
      ld_valid && ld_ready: begin
        sel = SRC_LD;
        req = '{wa: ld_wa, wd: ld_wd};
      end
      mdu_valid && mdu_ready: begin
        sel = SRC_MDU;
        req = '{wa: mdu_wa, wd: mdu_wd};
      end
      default: ;
    endcase
  end

  assign grant     = (sel != SRC_NONE);
  assign wr        = grant && (req.wa != REG_ZERO);
  assign mdu_go    = (sel == SRC_MDU);
  assign mdu_stall = mdu_valid && !mdu_ready;
  assign iss_ready = !sat;
  assign inc       = iss_en && (iss_wa != REG_ZERO);

  wb_scoreboard #(
    .CNT_W (SB_CNT_W)
  ) u_sb (
    .clk    (clk),
    .rst    (rst),
    .inc    (inc),
    .inc_wa (iss_wa),
    .dec    (wr),
    .dec_wa (req.wa),
    .q_a1   (chk_a1),
    .q_a2   (chk_a2),
    .busy1  (busy1),
    .busy2  (busy2),
    .sat_wa (iss_wa),
    .sat    (sat)
  );

  // starve is set on the edge that completes the
  // STARVE_MAX-th refused cycle; the MDU wins next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_cnt_q <= '0;
      starve_q <= 1'b0;
    end else begin
      if (!mdu_valid || mdu_go) begin
        st_cnt_q <= '0;
      end else if (st_cnt_q != ST_MAX) begin
        st_cnt_q <= st_cnt_q + ST_W'(1);
      end
      if (mdu_go) begin
        starve_q <= 1'b0;
      end else if (mdu_stall
                   && st_cnt_q >= ST_LAST) begin
        starve_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Wen <= 1'b0;
      Wa  <= '0;
      Wd  <= '0;
    end else begin
      Wen <= wr;
      if (grant) begin
        Wa <= req.wa;
        Wd <= req.wd;
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Randomized scoreboard bench for rf_writeback_arbiter
// against a behavioural writeback/hazard model.
module tb_rf_writeback_arbiter;

  localparam int SMAX = 8;
  localparam int CMAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid, mdu_valid;
  logic [4:0]  alu_wa, ld_wa, mdu_wa;
  logic [31:0] alu_wd, ld_wd, mdu_wd;
  logic        ld_ready, mdu_ready;
  logic        iss_en, iss_ready;
  logic [4:0]  iss_wa, chk_a1, chk_a2;
  logic        busy1, busy2;
  logic        Wen;
  logic [4:0]  Wa;
  logic [31:0] Wd;

  rf_writeback_arbiter #(
    .SB_CNT_W   (2),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_wa    (alu_wa),
    .alu_wd    (alu_wd),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_wa     (ld_wa),
    .ld_wd     (ld_wd),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_wa    (mdu_wa),
    .mdu_wd    (mdu_wd),
    .iss_en    (iss_en),
    .iss_wa    (iss_wa),
    .iss_ready (iss_ready),
    .chk_a1    (chk_a1),
    .chk_a2    (chk_a2),
    .busy1     (busy1),
    .busy2     (busy2),
    .Wen       (Wen),
    .Wa        (Wa),
    .Wd        (Wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    int          stamp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int   pend[32];
  bit   starve;
  int   waited;
  bit   ld_acc, mdu_acc;
  logic dut_mdr;

  task automatic chk(input string nm,
                     input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b",
               nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 0;
    starve = 0;
    waited = 0;
  endtask

  // One clock of stimulus: inputs already driven at negedge.
  task automatic cycle();
    bit         e_ldr, e_mdr, g, inc;
    logic [4:0] gwa;
    logic [31:0] gwd;
    #1;
    e_ldr = !alu_valid && !(starve && mdu_valid);
    e_mdr = !alu_valid && (starve || !ld_valid);
    dut_mdr = mdu_ready;
    chk("ld_ready", ld_ready, e_ldr);
    chk("mdu_ready", mdu_ready, e_mdr);
    chk("iss_ready", iss_ready, pend[iss_wa] < CMAX);
    chk("busy1", busy1, chk_a1 != 0 && pend[chk_a1] > 0);
    chk("busy2", busy2, chk_a2 != 0 && pend[chk_a2] > 0);
    ld_acc = 0;
    mdu_acc = 0;
    if (rst) begin
      model_reset();
    end else begin
      g = 1;
      gwa = 0;
      gwd = 0;
      if (alu_valid) begin
        gwa = alu_wa; gwd = alu_wd;
      end else if (ld_valid && e_ldr) begin
        gwa = ld_wa; gwd = ld_wd; ld_acc = 1;
      end else if (mdu_valid && e_mdr) begin
        gwa = mdu_wa; gwd = mdu_wd; mdu_acc = 1;
      end else begin
        g = 0;
      end
      if (g && gwa != 0)
        exp_q.push_back('{gwa, gwd, cyc + 1});
      inc = iss_en && iss_wa != 0 && pend[iss_wa] < CMAX;
      if (inc && g && gwa == iss_wa) begin
        // retire and issue cancel
      end else begin
        if (inc) pend[iss_wa]++;
        if (g && gwa != 0 && pend[gwa] > 0) pend[gwa]--;
      end
      if (mdu_acc) begin
        waited = 0; starve = 0;
      end else if (!mdu_valid) begin
        waited = 0;
      end else begin
        waited++;
        if (waited >= SMAX) starve = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid = 0; ld_valid = 0; mdu_valid = 0;
    iss_en = 0; chk_a1 = 0; chk_a2 = 0; iss_wa = 0;
    rst = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (Wen === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wen_spurious cyc=%0d Wa=%0d Wd=%h want=no write",
                   cyc, Wa, Wd);
        end else begin
          e = exp_q.pop_front();
          if (Wa !== e.wa || Wd !== e.wd || cyc != e.stamp) begin
            errors++;
            $display("FAIL write cyc=%0d got Wa=%0d Wd=%h want Wa=%0d Wd=%h at cyc=%0d",
                     cyc, Wa, Wd, e.wa, e.wd, e.stamp);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].stamp <= cyc) begin
        checks++;
        errors++;
        e = exp_q.pop_front();
        $display("FAIL wen_missing cyc=%0d got Wen=%b want Wa=%0d Wd=%h",
                 cyc, Wen, e.wa, e.wd);
      end
    end
  end

  initial begin : stim
    int got;
    idle();
    alu_wa = 0; alu_wd = 0; ld_wa = 0; ld_wd = 0;
    mdu_wa = 0; mdu_wd = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_wen", Wen, 1'b0);
    checks++;
    if (Wa !== 5'd0 || Wd !== 32'd0) begin
      errors++;
      $display("FAIL rst_wawd got Wa=%0d Wd=%h want 0/0", Wa, Wd);
    end
    idle();

    // ALU only
    alu_valid = 1; alu_wa = 5; alu_wd = 32'hDEAD_BEEF;
    cycle();
    idle(); cycle(); cycle();

    // three-way collision
    alu_valid = 1; alu_wa = 3; alu_wd = 32'h3333;
    ld_valid = 1; ld_wa = 4; ld_wd = 32'h4444;
    mdu_valid = 1; mdu_wa = 6; mdu_wd = 32'h6666;
    cycle();
    alu_valid = 0;
    cycle();
    ld_valid = 0;
    cycle();
    idle(); cycle();

    // scoreboard counting on r7
    iss_en = 1; iss_wa = 7; chk_a1 = 7;
    cycle(); cycle();
    iss_en = 0;
    ld_valid = 1; ld_wa = 7; ld_wd = 32'h7001;
    cycle();
    ld_wd = 32'h7002;
    cycle();
    ld_valid = 0; cycle();
    iss_en = 1; iss_wa = 7; cycle();
    ld_valid = 1; ld_wd = 32'h7003; cycle();
    idle(); chk_a1 = 7; cycle();

    // saturation on r9
    iss_en = 1; iss_wa = 9;
    cycle(); cycle(); cycle();
    iss_en = 0; cycle();
    ld_valid = 1; ld_wa = 9; ld_wd = 32'h9999; cycle();
    idle(); iss_wa = 9; cycle();

    // writes to $0
    ld_valid = 1; ld_wa = 0; ld_wd = 32'h1234;
    iss_en = 1; iss_wa = 0; chk_a1 = 0;
    cycle();
    idle(); cycle(); cycle();

    // starvation under back-to-back loads
    rst = 1; cycle(); idle(); cycle();
    got = 0;
    mdu_valid = 1; mdu_wa = 10; mdu_wd = 32'hA0A0;
    for (int i = 1; i <= 20; i++) begin
      ld_valid = 1;
      ld_wa = 5'($urandom_range(1, 31));
      ld_wd = $urandom;
      cycle();
      if (dut_mdr === 1'b1 && got == 0) got = i;
      if (mdu_acc) begin
        mdu_valid = 0;
        break;
      end
    end
    checks++;
    if (got != SMAX + 1) begin
      errors++;
      $display("FAIL starve_grant got cycle %0d want %0d", got, SMAX + 1);
    end

    // reset in the middle of a stall
    idle();
    iss_en = 1; iss_wa = 12; cycle();
    ld_valid = 1; ld_wa = 2; mdu_valid = 1; mdu_wa = 12;
    iss_en = 0;
    repeat (4) cycle();
    rst = 1; cycle();
    idle(); chk_a1 = 12; chk_a2 = 2; cycle(); cycle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom % 400 == 0);
      alu_valid = ($urandom % 3 == 0);
      alu_wa = 5'($urandom_range(0, 7));
      alu_wd = $urandom;
      if (!ld_valid || ld_acc) begin
        ld_valid = ($urandom % 2 == 0);
        ld_wa = 5'($urandom_range(0, 7));
        ld_wd = $urandom;
      end
      if (!mdu_valid || mdu_acc) begin
        mdu_valid = ($urandom % 3 == 0);
        mdu_wa = 5'($urandom_range(0, 7));
        mdu_wd = $urandom;
      end
      iss_wa = 5'($urandom_range(0, 7));
      iss_en = ($urandom % 2 == 0) && pend[iss_wa] < CMAX;
      chk_a1 = 5'($urandom_range(0, 7));
      chk_a2 = 5'($urandom_range(0, 7));
      cycle();
      if (rst) begin
        ld_valid = 0;
        mdu_valid = 0;
      end
    end

    idle();
    repeat (4) cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending writes want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
